// File: rtl/blink_arbiter_if.sv
// Signal bundle between blink_arbiter, its four blink requesters and the
// shared LED pattern generator.
interface blink_arbiter_if;
  logic [3:0]  req;
  logic        pat_done;
  logic [31:0] ontime;
  logic [31:0] offtime;
  logic [7:0]  reps;
  logic        pat_enable;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  done_pulse;
  logic [3:0]  abort_pulse;

  modport slave (
    input  req, pat_done,
    output ontime, offtime, reps, pat_enable, grant, busy, done_pulse, abort_pulse
  );

  modport master (
    output req, pat_done,
    input  ontime, offtime, reps, pat_enable, grant, busy, done_pulse, abort_pulse
  );
endinterface

// File: rtl/blink_arbiter.sv
// Time-shares one LED pattern generator between four pulsed requesters with
// fixed priority (bit 0 highest), optional pre-emption, a dark gap and a watchdog.
module blink_arbiter #(
  parameter logic [31:0] ON_0       = 32'd12000000,
  parameter logic [31:0] ON_1       = 32'd2400000,
  parameter logic [31:0] ON_2       = 32'd6000000,
  parameter logic [31:0] ON_3       = 32'd1200000,
  parameter logic [31:0] OFF_0      = 32'd6000000,
  parameter logic [31:0] OFF_1      = 32'd2400000,
  parameter logic [31:0] OFF_2      = 32'd6000000,
  parameter logic [31:0] OFF_3      = 32'd1200000,
  parameter logic [7:0]  REPS_0     = 8'd3,
  parameter logic [7:0]  REPS_1     = 8'd5,
  parameter logic [7:0]  REPS_2     = 8'd2,
  parameter logic [7:0]  REPS_3     = 8'd1,
  parameter logic [31:0] GAP_CYCLES = 32'd1200000,
  parameter logic        PREEMPT    = 1'b1,
  parameter logic [31:0] WATCHDOG   = 32'd0
) (
  input  logic           hwclk,
  input  logic           resetN,
  blink_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } stateT;

  stateT       stateR, stateS;
  logic [3:0]  pendingR, pendingS;
  logic [3:0]  grantR, grantS;
  logic [31:0] ontimeR, ontimeS;
  logic [31:0] offtimeR, offtimeS;
  logic [7:0]  repsR, repsS;
  logic [3:0]  doneR, doneS;
  logic [3:0]  abortR, abortS;
  logic [31:0] wdCntR, wdCntS;
  logic [31:0] gapCntR, gapCntS;
  logic        patEnableR;
  logic        busyR;
  logic        grantNowS;
  logic [1:0]  pickS;
  logic [3:0]  higherS;

  function automatic logic [1:0] lowestIdx(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [71:0] preset(input logic [1:0] k);
    logic [71:0] p;
    case (k)
      2'd0:    p = {ON_0, OFF_0, REPS_0};
      2'd1:    p = {ON_1, OFF_1, REPS_1};
      2'd2:    p = {ON_2, OFF_2, REPS_2};
      default: p = {ON_3, OFF_3, REPS_3};
    endcase
    return p;
  endfunction

  // Next state, slot selection and next value of every registered output.
  always_comb begin
    stateS    = stateR;
    grantS    = grantR;
    ontimeS   = ontimeR;
    offtimeS  = offtimeR;
    repsS     = repsR;
    doneS     = 4'b0000;
    abortS    = 4'b0000;
    wdCntS    = wdCntR;
    gapCntS   = gapCntR;
    grantNowS = 1'b0;
    pickS     = lowestIdx(pendingR);
    // grantR is one-hot in RUN, so grantR-1 masks exactly the higher-priority slots
    higherS   = pendingR & (grantR - 4'b0001);
    case (stateR)
      IDLE: begin
        grantNowS = (pendingR != 4'b0000);
        stateS    = grantNowS ? LOAD : IDLE;
      end
      LOAD: begin
        wdCntS = 32'd0;
        stateS = RUN;
      end
      RUN: begin
        wdCntS = satInc(wdCntR);
        if (bus.pat_done) begin
          doneS   = grantR;
          gapCntS = 32'd0;
          stateS  = GAP;
        end else if (PREEMPT && (higherS != 4'b0000)) begin
          abortS    = grantR;
          grantNowS = 1'b1;
          stateS    = LOAD;
        end else if ((WATCHDOG != 32'd0) && (wdCntS >= WATCHDOG)) begin
          abortS  = grantR;
          gapCntS = 32'd0;
          stateS  = GAP;
        end else begin
          stateS = RUN;
        end
      end
      GAP: begin
        gapCntS = satInc(gapCntR);
        stateS  = (gapCntR >= (GAP_CYCLES - 32'd1)) ? IDLE : GAP;
      end
      default: stateS = IDLE;
    endcase
    if (grantNowS) begin
      grantS                      = 4'b0001 << pickS;
      {ontimeS, offtimeS, repsS}  = preset(pickS);
    end else begin
      grantS = ((stateS == GAP) || (stateS == IDLE)) ? 4'b0000 : grantR;
    end
    // a request arriving in the grant cycle re-arms the slot
    pendingS = (pendingR & ~(grantNowS ? grantS : 4'b0000)) | bus.req;
  end

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge hwclk or negedge resetN) begin
    if (!resetN) begin
      stateR     <= IDLE;
      pendingR   <= 4'b0000;
      grantR     <= 4'b0000;
      ontimeR    <= 32'd0;
      offtimeR   <= 32'd0;
      repsR      <= 8'd0;
      doneR      <= 4'b0000;
      abortR     <= 4'b0000;
      wdCntR     <= 32'd0;
      gapCntR    <= 32'd0;
      patEnableR <= 1'b0;
      busyR      <= 1'b0;
    end else begin
      stateR     <= stateS;
      pendingR   <= pendingS;
      grantR     <= grantS;
      ontimeR    <= ontimeS;
      offtimeR   <= offtimeS;
      repsR      <= repsS;
      doneR      <= doneS;
      abortR     <= abortS;
      wdCntR     <= wdCntS;
      gapCntR    <= gapCntS;
      patEnableR <= (stateS == RUN);
      busyR      <= (stateS != IDLE);
    end
  end

  assign bus.ontime      = ontimeR;
  assign bus.offtime     = offtimeR;
  assign bus.reps        = repsR;
  assign bus.pat_enable  = patEnableR;
  assign bus.grant       = grantR;
  assign bus.busy        = busyR;
  assign bus.done_pulse  = doneR;
  assign bus.abort_pulse = abortR;

endmodule

// File: tb/tb_blink_arbiter.sv
// Scoreboard bench for blink_arbiter: instance A pre-empts and has a 10-cycle
// watchdog, instance B never pre-empts; both use a 4-cycle gap.
`timescale 1ns/1ps
module tb_blink_arbiter;
  logic        hwclk = 1'b0;
  logic        resetN = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  logic [47:0] sbA[$];
  logic [47:0] sbB[$];
  logic [3:0]  prevGrantA = 4'b0000;
  logic [3:0]  prevGrantB = 4'b0000;

  blink_arbiter_if busA();
  blink_arbiter_if busB();

  always #5 hwclk = ~hwclk;

  blink_arbiter #(.GAP_CYCLES(32'd4), .PREEMPT(1'b1), .WATCHDOG(32'd10)) dutA (
    .hwclk(hwclk), .resetN(resetN), .bus(busA));
  blink_arbiter #(.GAP_CYCLES(32'd4), .PREEMPT(1'b0), .WATCHDOG(32'd0)) dutB (
    .hwclk(hwclk), .resetN(resetN), .bus(busB));

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Expected events: kind 1 = grant with presets, 2 = abort, 3 = done.
  function automatic logic [47:0] grantEv(input int s);
    logic [31:0] on;
    logic [7:0]  rp;
    logic [3:0]  oh;
    oh = 4'b0001 << s;
    case (s)
      0:       begin on = 32'd12000000; rp = 8'd3; end
      1:       begin on = 32'd2400000;  rp = 8'd5; end
      2:       begin on = 32'd6000000;  rp = 8'd2; end
      default: begin on = 32'd1200000;  rp = 8'd1; end
    endcase
    return {4'h1, oh, on, rp};
  endfunction

  function automatic logic [47:0] pulseEv(input logic [3:0] kind, input int s);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    return {kind, oh, 40'd0};
  endfunction

  task automatic scoreA(input string tag, input logic [47:0] ev);
    logic [47:0] exp;
    if (sbA.size() == 0) begin
      checkValue({tag, "_unexpected"}, {16'd0, ev}, 64'd0);
    end else begin
      exp = sbA.pop_front();
      checkValue(tag, {16'd0, ev}, {16'd0, exp});
    end
  endtask

  task automatic scoreB(input string tag, input logic [47:0] ev);
    logic [47:0] exp;
    if (sbB.size() == 0) begin
      checkValue({tag, "_unexpected"}, {16'd0, ev}, 64'd0);
    end else begin
      exp = sbB.pop_front();
      checkValue(tag, {16'd0, ev}, {16'd0, exp});
    end
  endtask

  // Turn observed grants and pulses into events and match them against the queues.
  always @(negedge hwclk) begin
    if (resetN) begin
      if (busA.abort_pulse != 4'b0000) scoreA("sbA_abort", {4'h2, busA.abort_pulse, 40'd0});
      if (busA.done_pulse != 4'b0000) scoreA("sbA_done", {4'h3, busA.done_pulse, 40'd0});
      if (busA.grant != 4'b0000 && busA.grant != prevGrantA)
        scoreA("sbA_grant", {4'h1, busA.grant, busA.ontime, busA.reps});
      if (busB.abort_pulse != 4'b0000) scoreB("sbB_abort", {4'h2, busB.abort_pulse, 40'd0});
      if (busB.done_pulse != 4'b0000) scoreB("sbB_done", {4'h3, busB.done_pulse, 40'd0});
      if (busB.grant != 4'b0000 && busB.grant != prevGrantB)
        scoreB("sbB_grant", {4'h1, busB.grant, busB.ontime, busB.reps});
    end
    prevGrantA = busA.grant;
    prevGrantB = busB.grant;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic pulse(input bit onB, input logic [3:0] m);
    if (onB) busB.req = m; else busA.req = m;
    tick(1);
    busA.req = 4'b0000;
    busB.req = 4'b0000;
  endtask

  task automatic patDone(input bit onB);
    if (onB) busB.pat_done = 1'b1; else busA.pat_done = 1'b1;
    tick(1);
    busA.pat_done = 1'b0;
    busB.pat_done = 1'b0;
  endtask

  task automatic waitEn(input bit onB, input string tag);
    int k = 0;
    while (!(onB ? busB.pat_enable : busA.pat_enable) && k < 40) begin
      tick(1);
      k++;
    end
    checkValue(tag, 64'(onB ? busB.pat_enable : busA.pat_enable), 64'd1);
  endtask

  task automatic waitIdle(input bit onB, input string tag);
    int k = 0;
    while ((onB ? busB.busy : busA.busy) && k < 40) begin
      tick(1);
      k++;
    end
    checkValue(tag, 64'(onB ? busB.busy : busA.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared %0d", compared);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    busA.req = 4'b0000; busA.pat_done = 1'b0;
    busB.req = 4'b0000; busB.pat_done = 1'b0;
    tick(2);
    checkValue("rst_grant", 64'(busA.grant), 64'd0);
    checkValue("rst_busy", 64'(busA.busy), 64'd0);
    checkValue("rst_en", 64'(busA.pat_enable), 64'd0);
    checkValue("rst_ontime", 64'(busA.ontime), 64'd0);
    checkValue("rst_reps", 64'(busA.reps), 64'd0);
    checkValue("rst_pulses", 64'({busA.done_pulse, busA.abort_pulse}), 64'd0);
    checkValue("rst_B_busy", 64'(busB.busy), 64'd0);
    resetN = 1'b1;
    tick(2);

    // Single request on slot 1 with exact latency and gap length.
    sbA.push_back(grantEv(1));
    pulse(0, 4'b0010);
    checkValue("t1_busy_e0", 64'(busA.busy), 64'd0);
    tick(1);
    checkValue("t1_grant", 64'(busA.grant), 64'h2);
    checkValue("t1_ontime", 64'(busA.ontime), 64'd2400000);
    checkValue("t1_offtime", 64'(busA.offtime), 64'd2400000);
    checkValue("t1_reps", 64'(busA.reps), 64'd5);
    checkValue("t1_busy_e1", 64'(busA.busy), 64'd1);
    checkValue("t1_en_load", 64'(busA.pat_enable), 64'd0);
    tick(1);
    checkValue("t1_en_run", 64'(busA.pat_enable), 64'd1);
    sbA.push_back(pulseEv(4'h3, 1));
    patDone(0);
    checkValue("t1_done", 64'(busA.done_pulse), 64'h2);
    checkValue("t1_en_off", 64'(busA.pat_enable), 64'd0);
    checkValue("t1_grant_gap", 64'(busA.grant), 64'd0);
    tick(1);
    checkValue("t1_done_1cyc", 64'(busA.done_pulse), 64'd0);
    tick(2);
    checkValue("t1_busy_gap", 64'(busA.busy), 64'd1);
    tick(1);
    checkValue("t1_idle", 64'(busA.busy), 64'd0);
    checkValue("t1_ontime_hold", 64'(busA.ontime), 64'd2400000);

    // Priority: slot 2 before slot 3; repeated slot 3 requests merge.
    sbA.push_back(grantEv(2));
    pulse(0, 4'b1100);
    tick(1);
    pulse(0, 4'b1000);
    pulse(0, 4'b1000);
    checkValue("t2_slot2_run", 64'({busA.grant, 3'b000, busA.pat_enable}), 64'h41);
    sbA.push_back(pulseEv(4'h3, 2));
    sbA.push_back(grantEv(3));
    patDone(0);
    waitEn(0, "t2_slot3_en");
    sbA.push_back(pulseEv(4'h3, 3));
    patDone(0);
    waitIdle(0, "t2_idle");
    tick(5);
    checkValue("t2_slot3_once", 64'(busA.busy), 64'd0);

    // Pre-emption of slot 3 by slot 0.
    sbA.push_back(grantEv(3));
    pulse(0, 4'b1000);
    waitEn(0, "t3_slot3_en");
    tick(1);
    sbA.push_back(pulseEv(4'h2, 3));
    sbA.push_back(grantEv(0));
    pulse(0, 4'b0001);
    checkValue("t3_no_abort_yet", 64'(busA.abort_pulse), 64'd0);
    tick(1);
    checkValue("t3_abort", 64'(busA.abort_pulse), 64'h8);
    checkValue("t3_grant", 64'(busA.grant), 64'h1);
    checkValue("t3_ontime", 64'(busA.ontime), 64'd12000000);
    checkValue("t3_offtime", 64'(busA.offtime), 64'd6000000);
    checkValue("t3_reps", 64'(busA.reps), 64'd3);
    checkValue("t3_load_en", 64'(busA.pat_enable), 64'd0);
    tick(1);
    checkValue("t3_run_en", 64'({busA.abort_pulse, 3'b000, busA.pat_enable}), 64'h1);
    sbA.push_back(pulseEv(4'h3, 0));
    patDone(0);
    waitIdle(0, "t3_idle");
    tick(5);
    checkValue("t3_no_rerun", 64'(busA.busy), 64'd0);

    // Done wins over a pre-emption request visible in the same cycle.
    sbA.push_back(grantEv(2));
    pulse(0, 4'b0100);
    waitEn(0, "t4_slot2_en");
    busA.req = 4'b0001;
    tick(1);
    busA.req = 4'b0000;
    sbA.push_back(pulseEv(4'h3, 2));
    sbA.push_back(grantEv(0));
    patDone(0);
    checkValue("t4_done", 64'(busA.done_pulse), 64'h4);
    checkValue("t4_no_abort", 64'(busA.abort_pulse), 64'd0);
    waitEn(0, "t4_slot0_en");
    checkValue("t4_slot0_grant", 64'(busA.grant), 64'h1);
    sbA.push_back(pulseEv(4'h3, 0));
    patDone(0);
    waitIdle(0, "t4_idle");

    // Watchdog: pat_done never arrives.
    sbA.push_back(grantEv(1));
    sbA.push_back(pulseEv(4'h2, 1));
    pulse(0, 4'b0010);
    waitEn(0, "t5_en");
    n = 0;
    while (busA.pat_enable && n < 40) begin
      tick(1);
      n++;
    end
    checkValue("t5_run_cycles", 64'(n), 64'd10);
    checkValue("t5_abort", 64'(busA.abort_pulse), 64'h2);
    checkValue("t5_gap_busy", 64'(busA.busy), 64'd1);
    waitIdle(0, "t5_idle");

    // No pre-emption on instance B: slot 0 waits for slot 3.
    sbB.push_back(grantEv(3));
    pulse(1, 4'b1000);
    waitEn(1, "t6_slot3_en");
    pulse(1, 4'b0001);
    tick(2);
    checkValue("t6_no_abort", 64'(busB.abort_pulse), 64'd0);
    checkValue("t6_still3", 64'(busB.grant), 64'h8);
    sbB.push_back(pulseEv(4'h3, 3));
    sbB.push_back(grantEv(0));
    patDone(1);
    waitEn(1, "t6_slot0_en");
    checkValue("t6_slot0_grant", 64'(busB.grant), 64'h1);
    sbB.push_back(pulseEv(4'h3, 0));
    patDone(1);
    waitIdle(1, "t6_idle");

    // Asynchronous reset in the middle of RUN with slot 3 still pending.
    sbA.push_back(grantEv(1));
    pulse(0, 4'b0010);
    waitEn(0, "t7_en");
    pulse(0, 4'b1000);
    #2;
    resetN = 1'b0;
    #1;
    checkValue("t7_rst_en", 64'(busA.pat_enable), 64'd0);
    checkValue("t7_rst_grant", 64'(busA.grant), 64'd0);
    checkValue("t7_rst_busy", 64'(busA.busy), 64'd0);
    tick(1);
    resetN = 1'b1;
    tick(1);
    sbA.push_back(grantEv(2));
    pulse(0, 4'b0100);
    waitEn(0, "t7_slot2_en");
    checkValue("t7_slot2_grant", 64'(busA.grant), 64'h4);
    sbA.push_back(pulseEv(4'h3, 2));
    patDone(0);
    waitIdle(0, "t7_idle");
    tick(5);
    checkValue("t7_old_pending_gone", 64'(busA.busy), 64'd0);

    checkValue("sbA_drained", 64'(sbA.size()), 64'd0);
    checkValue("sbB_drained", 64'(sbB.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
